// File: rtl/fp_to_int_conv.sv
// fp_to_int_conv
//   Converts an IEEE-754 binary32 operand into int32 or uint32, rounding
//   toward zero. The block is a multi-cycle FSM that handles one operand at
//   a time: IDLE -> DECODE -> ALIGN* -> NEGATE -> DONE.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_valid      : operand offered
//   in_ready      : high only in IDLE
//   fp_in         : binary32 operand, captured at the accept edge
//   is_signed     : 1 = int32 result, 0 = uint32 result
//   out_valid     : high only in DONE
//   out_ready     : consumer accepts the result
//   int_out       : converted integer, held through DONE
//   flag_invalid  : NaN, overflow, or negative value for an unsigned result
//   flag_inexact  : a nonzero fraction was discarded
module fp_to_int_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ALIGN,
    S_NEGATE,
    S_DONE
  } state_t;

  // Captured operand; bit layout matches {fp_in, is_signed}.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        sgn_mode;
  } op_t;

  localparam logic [31:0] MAX_S = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_U = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_S = 32'h8000_0000;

  state_t      state_q, state_d;
  op_t         op_q;
  logic [31:0] mag_q, res_q;
  logic [4:0]  rem_q;
  logic        sticky_q, inv_q, inx_q;

  // ---------------- decode ----------------
  logic signed [9:0] e;
  logic [23:0] m;
  logic [4:0]  lsh, r_init;
  logic        special, spec_inv, spec_inx;
  logic [31:0] spec_res;

  always_comb begin
    e        = $signed({2'b00, op_q.exp}) - 10'sd127;
    m        = {1'b1, op_q.frac};
    // Only consulted when 0 <= e <= 31, so the low 5 bits of e suffice.
    lsh      = e[4:0] - 5'd23;
    r_init   = 5'd23 - e[4:0];
    special  = 1'b1;
    spec_res = '0;
    spec_inv = 1'b0;
    spec_inx = 1'b0;
    if ((&op_q.exp) && (|op_q.frac)) begin
      spec_res = op_q.sgn_mode ? MAX_S : MAX_U;
      spec_inv = 1'b1;
    end else if (op_q.exp == 8'd0) begin
      spec_inx = |op_q.frac;               // zero or subnormal
    end else if (e < 10'sd0) begin
      spec_inx = 1'b1;                     // 0 < |x| < 1
    end else if (op_q.sign && !op_q.sgn_mode) begin
      spec_inv = 1'b1;                     // x <= -1 into uint32 (incl. -Inf)
    end else if (op_q.sign) begin
      if (e >= 10'sd31) begin
        spec_res = MIN_S;
        // -2^31 is the one representable value at this magnitude.
        spec_inv = !((op_q.exp == 8'd158) && (op_q.frac == 23'd0));
      end else begin
        special = 1'b0;
      end
    end else if ((op_q.sgn_mode && e >= 10'sd31) || (!op_q.sgn_mode && e >= 10'sd32)) begin
      spec_res = op_q.sgn_mode ? MAX_S : MAX_U;   // also covers +Inf
      spec_inv = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // ---------------- align step ----------------
  logic [3:0]  sh;
  logic [7:0]  lost_mask;
  logic        lost;
  logic [4:0]  rem_next;
  logic [31:0] mag_next;

  always_comb begin
    sh        = (rem_q > 5'd8) ? 4'd8 : rem_q[3:0];
    lost_mask = 8'hFF >> (4'd8 - sh);
    lost      = |(mag_q[7:0] & lost_mask);
    mag_next  = mag_q >> sh;
    rem_next  = rem_q - {1'b0, sh};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (special)           state_d = S_DONE;
        else if (e >= 10'sd23) state_d = S_NEGATE;
        else                   state_d = S_ALIGN;
      end
      S_ALIGN:  if (rem_next == 5'd0) state_d = S_NEGATE;
      S_NEGATE: state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      mag_q    <= '0;
      res_q    <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q     <= {fp_in, is_signed};
          sticky_q <= 1'b0;
        end
        S_DECODE: begin
          sticky_q <= 1'b0;
          if (special) begin
            res_q <= spec_res;
            inv_q <= spec_inv;
            inx_q <= spec_inx;
          end else if (e >= 10'sd23) begin
            mag_q <= {8'd0, m} << lsh;
            rem_q <= 5'd0;
          end else begin
            mag_q <= {8'd0, m};
            rem_q <= r_init;
          end
        end
        S_ALIGN: begin
          mag_q    <= mag_next;
          rem_q    <= rem_next;
          sticky_q <= sticky_q | lost;
        end
        S_NEGATE: begin
          res_q <= (op_q.sign && op_q.sgn_mode) ? -mag_q : mag_q;
          inv_q <= 1'b0;
          inx_q <= sticky_q;
        end
        S_DONE: if (out_ready) begin
          inv_q <= 1'b0;
          inx_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign int_out      = res_q;
  assign flag_invalid = inv_q & out_valid;
  assign flag_inexact = inx_q & out_valid;

endmodule
